change_dispense_ctrl: RTL and testbench

Sequences the return of change after a purchase or cancel in the vending machine. It takes a change amount in cents and drives a coin hopper one coin at a time over a req/ack handshake. It chooses denominations greedily (dollar > quarter > dime) and skips empty hoppers. It sits between the vending FSM, which supplies `start` and `change_in` on entry to its result state, and the hopper interface. It reports completion, any unpayable residue, and hopper timeouts.

---
 rtl/vm_pkg.sv | 28 ++
 rtl/change_dispense_ctrl_if.sv | 44 ++++
 rtl/change_coin_pick.sv | 46 ++++
 rtl/change_dispense_ctrl.sv | 156 +++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin select encoding, status codes and coin values.
// Used by the change dispenser and the coin-collection logic.
package vm_pkg;

    localparam int AMT_W_DEF     = 8;
    localparam int DOLLAR_CENTS  = 100;
    localparam int QUARTER_CENTS = 25;
    localparam int DIME_CENTS    = 10;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_DOLLAR  = 2'b11
    } coin_sel_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SHORT   = 2'd1,
        ST_TIMEOUT = 2'd2
    } status_e;

    // hopper_empty bit positions: {dollar, quarter, dime}
    localparam int HOP_DIME    = 0;
    localparam int HOP_QUARTER = 1;
    localparam int HOP_DOLLAR  = 2;

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Bundle between the vending FSM / coin hopper side and the change dispenser.
// The slave modport is the dispenser's view; master is the environment's view.
interface change_dispense_ctrl_if #(
    parameter int AMT_W = vm_pkg::AMT_W_DEF
) ();

    logic             start;
    logic [AMT_W-1:0] change_in;
    logic [2:0]       hopper_empty;
    logic             coin_ack;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [AMT_W-1:0] remaining;

    modport slave (
        input  start,
        input  change_in,
        input  hopper_empty,
        input  coin_ack,
        output coin_req,
        output coin_sel,
        output busy,
        output done,
        output status,
        output remaining
    );

    modport master (
        output start,
        output change_in,
        output hopper_empty,
        output coin_ack,
        input  coin_req,
        input  coin_sel,
        input  busy,
        input  done,
        input  status,
        input  remaining
    );

endinterface

// File: rtl/change_coin_pick.sv
// Combinational greedy coin picker: largest denomination that fits the amount
// and whose hopper is not empty (dollar > quarter > dime).
module change_coin_pick
    import vm_pkg::*;
#(
    parameter int AMT_W     = AMT_W_DEF,
    parameter int DOLLAR_C  = DOLLAR_CENTS,
    parameter int QUARTER_C = QUARTER_CENTS,
    parameter int DIME_C    = DIME_CENTS
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       hopper_empty,
    output coin_sel_e        coin_sel,
    output logic [AMT_W-1:0] coin_val
);

    // Packed per-denomination values, indexed like hopper_empty
    localparam logic [3*AMT_W-1:0] VALS = {AMT_W'(DOLLAR_C), AMT_W'(QUARTER_C), AMT_W'(DIME_C)};

    logic [AMT_W-1:0] den_val [3];
    logic [2:0]       eligible;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_den
            assign den_val[gi]  = VALS[gi*AMT_W +: AMT_W];
            assign eligible[gi] = !hopper_empty[gi] && (remaining >= den_val[gi]);
        end
    endgenerate

    always_comb begin
        coin_sel = COIN_NONE;
        coin_val = '0;
        if (eligible[HOP_DOLLAR]) begin
            coin_sel = COIN_DOLLAR;
            coin_val = den_val[HOP_DOLLAR];
        end else if (eligible[HOP_QUARTER]) begin
            coin_sel = COIN_QUARTER;
            coin_val = den_val[HOP_QUARTER];
        end else if (eligible[HOP_DIME]) begin
            coin_sel = COIN_DIME;
            coin_val = den_val[HOP_DIME];
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser: pays out an amount one coin at a time over a req/ack hopper
// handshake, reporting OK, SHORT (unpayable residue) or TIMEOUT on completion.
module change_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEF,
    parameter int DOLLAR_C    = DOLLAR_CENTS,
    parameter int QUARTER_C   = QUARTER_CENTS,
    parameter int DIME_C      = DIME_CENTS,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 2
) (
    input logic                  clk,
    input logic                  rst,
    change_dispense_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_GAP,
        S_DONE
    } state_e;

    // ACK_TIMEOUT and GAP_CYCLES are both expected to be at least 1
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    status_e          status_q, status_d;
    logic             coin_req_q, coin_req_d;
    coin_sel_e        coin_sel_q, coin_sel_d;
    logic [AMT_W-1:0] coin_val_q, coin_val_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    coin_sel_e        pick_sel;
    logic [AMT_W-1:0] pick_val;

    change_coin_pick #(
        .AMT_W     (AMT_W),
        .DOLLAR_C  (DOLLAR_C),
        .QUARTER_C (QUARTER_C),
        .DIME_C    (DIME_C)
    ) u_pick (
        .remaining    (remaining_q),
        .hopper_empty (bus.hopper_empty),
        .coin_sel     (pick_sel),
        .coin_val     (pick_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            status_q    <= ST_OK;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= COIN_NONE;
            coin_val_q  <= '0;
            timer_q     <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            status_q    <= status_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            coin_val_q  <= coin_val_d;
            timer_q     <= timer_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        status_d    = status_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        coin_val_d  = coin_val_q;
        timer_d     = timer_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.change_in;
                    status_d    = ST_OK;
                    state_d     = S_SELECT;
                end
            end

            S_SELECT: begin
                if (remaining_q == '0) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else if (pick_sel != COIN_NONE) begin
                    coin_sel_d = pick_sel;
                    coin_val_d = pick_val;
                    coin_req_d = 1'b1;
                    timer_d    = '0;
                    state_d    = S_REQ;
                end else begin
                    status_d = ST_SHORT;
                    state_d  = S_DONE;
                end
            end

            S_REQ: begin
                // An ack on the expiry edge takes priority over the timeout
                if (bus.coin_ack) begin
                    remaining_d = remaining_q - coin_val_q;
                    coin_req_d  = 1'b0;
                    coin_sel_d  = COIN_NONE;
                    gap_cnt_d   = '0;
                    state_d     = S_GAP;
                end else if (timer_q == TMR_LAST) begin
                    coin_req_d = 1'b0;
                    coin_sel_d = COIN_NONE;
                    status_d   = ST_TIMEOUT;
                    state_d    = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.coin_req  = coin_req_q;
    assign bus.coin_sel  = coin_sel_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.status    = status_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: expected coins and running remainders are
// queued when a transaction starts and popped as the hopper handshake progresses.
module tb_change_dispense_ctrl;
    import vm_pkg::*;

    localparam int TB_ACK_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    change_dispense_ctrl_if #(.AMT_W(8)) bus ();

    change_dispense_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_coin_q [$];
    logic [7:0] exp_rem_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_coin(input logic [1:0] sel, input logic [7:0] rem_after);
        exp_coin_q.push_back(sel);
        exp_rem_q.push_back(rem_after);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coin_req"},  32'(bus.coin_req),  32'd0);
        check({tag, "_coin_sel"},  32'(bus.coin_sel),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_status"},    32'(bus.status),    32'd0);
        check({tag, "_remaining"}, 32'(bus.remaining), 32'd0);
    endtask

    // One transaction; the bench plays the hopper, acking one cycle after each req rises.
    task automatic run_change(input string name, input logic [7:0] amt, input logic [2:0] empty,
                              input bit ack_on, input bit poke_start,
                              input logic [1:0] exp_status, input logic [7:0] exp_rem);
        int         req_len     = 0;
        int         cyc         = 0;
        bit         ack_pending = 1'b0;
        bit         done_seen   = 1'b0;
        logic [1:0] es;
        logic [7:0] er;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.change_in    = amt;
        bus.hopper_empty = empty;
        @(negedge clk);
        bus.start = 1'b0;
        check({name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        check({name, "_status_cleared"}, 32'(bus.status), 32'(ST_OK));
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (poke_start && cyc == 3) begin
                bus.start     = 1'b1;
                bus.change_in = 8'd200;
            end
            if (ack_pending) begin
                ack_pending  = 1'b0;
                bus.coin_ack = 1'b0;
                check({name, "_req_drop_on_ack"}, 32'(bus.coin_req), 32'd0);
                er = (exp_rem_q.size() != 0) ? exp_rem_q.pop_front() : 8'hEE;
                check({name, "_remaining"}, 32'(bus.remaining), 32'(er));
                req_len = 0;
            end else if (bus.coin_req) begin
                if (req_len == 0) begin
                    es = (exp_coin_q.size() != 0) ? exp_coin_q.pop_front() : COIN_NONE;
                    check({name, "_coin_sel"}, 32'(bus.coin_sel), 32'(es));
                end
                req_len++;
                if (ack_on && req_len == 2) begin
                    bus.coin_ack = 1'b1;
                    ack_pending  = 1'b1;
                end
            end else if (req_len != 0) begin
                check({name, "_req_high_cycles"}, 32'(req_len), 32'(TB_ACK_TIMEOUT));
                check({name, "_done_after_timeout"}, 32'(bus.done), 32'd1);
                req_len = 0;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                check({name, "_status"}, 32'(bus.status), 32'(exp_status));
                check({name, "_final_remaining"}, 32'(bus.remaining), 32'(exp_rem));
                check({name, "_coins_left"}, 32'(exp_coin_q.size()), 32'd0);
                if (amt == 8'd0)
                    check({name, "_done_latency"}, 32'(cyc), 32'd1);
            end
        end
        check({name, "_done_seen"}, 32'(done_seen), 32'd1);
        @(negedge clk);
        check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_status_held"}, 32'(bus.status), 32'(exp_status));
        exp_coin_q.delete();
        exp_rem_q.delete();
        $display("txn %s amt=%0d status=%0d remaining=%0d", name, amt, bus.status, bus.remaining);
    endtask

    initial begin
        int cyc;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.change_in    = '0;
        bus.hopper_empty = 3'b000;
        bus.coin_ack     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_change("zero", 8'd0, 3'b000, 1'b1, 1'b0, ST_OK, 8'd0);

        push_coin(COIN_DOLLAR, 8'd35);
        push_coin(COIN_QUARTER, 8'd10);
        push_coin(COIN_DIME, 8'd0);
        run_change("c135", 8'd135, 3'b000, 1'b1, 1'b0, ST_OK, 8'd0);

        push_coin(COIN_QUARTER, 8'd40);
        push_coin(COIN_QUARTER, 8'd15);
        push_coin(COIN_DIME, 8'd5);
        run_change("c65", 8'd65, 3'b000, 1'b1, 1'b0, ST_SHORT, 8'd5);

        for (int i = 0; i < 4; i++)
            push_coin(COIN_QUARTER, 8'(75 - 25 * i));
        run_change("c100_no_dollar", 8'd100, 3'b100, 1'b1, 1'b0, ST_OK, 8'd0);

        push_coin(COIN_QUARTER, 8'd10);
        push_coin(COIN_DIME, 8'd0);
        run_change("c35_start_ignored", 8'd35, 3'b000, 1'b1, 1'b1, ST_OK, 8'd0);

        push_coin(COIN_QUARTER, 8'd50);
        run_change("c50_timeout", 8'd50, 3'b000, 1'b0, 1'b0, ST_TIMEOUT, 8'd50);

        // Reset while a quarter is being requested during change 80
        @(negedge clk);
        bus.start        = 1'b1;
        bus.change_in    = 8'd80;
        bus.hopper_empty = 3'b000;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.coin_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_req_seen", 32'(bus.coin_req), 32'd1);
        check("rst_mid_sel", 32'(bus.coin_sel), 32'(COIN_QUARTER));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_no_done", 32'(bus.done), 32'd0);
        end
        $display("txn rst_mid amt=80 coin_req=%0d busy=%0d", bus.coin_req, bus.busy);

        push_coin(COIN_DIME, 8'd0);
        run_change("c10_after_reset", 8'd10, 3'b000, 1'b1, 1'b0, ST_OK, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
